// File: rtl/rtlola_input_aligner_if.sv
// ---------------------------------------------------------------------------
// rtlola_input_aligner_if
// Producer-side event handshake for the RTLola input aligner.
//
// Handshake: an event transfers on a rising clock edge where in_valid and
// in_ready are both high (and the aligner is enabled). The producer keeps
// in_valid and in_data stable until that transfer. in_ready does not depend
// on in_valid.
//
// Signals:
//   in_valid  producer -> aligner   producer has an event
//   in_ready  aligner  -> producer  aligner can accept (buffer not full)
//   in_data   producer -> aligner   signed event payload, DATA_W bits
// Modports:
//   master    producer side
//   slave     aligner side
// ---------------------------------------------------------------------------
interface rtlola_input_aligner_if #(
  parameter int DATA_W = 64
) ();
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/rtlola_input_aligner.sv
// ---------------------------------------------------------------------------
// rtlola_input_aligner
// Buffers producer events in a small FIFO and presents each one to the RTLola
// monitor so that new_input is high exactly in the cycle where the monitor's
// llc_stage is 0. The issue decision is taken in the last stage of an HLC
// period and registered, so the strobe lands on stage 0.
//
// Ports:
//   clk           clock, all state on rising edge
//   rst           synchronous reset, active low
//   en            global enable (same as monitor en); 0 freezes all state
//   prod          producer handshake (slave modport: in_valid/in_ready/in_data)
//   llc_stage     signed stage index fed back from the monitor
//   input_a       last issued event value (registered)
//   new_input     one-cycle event strobe (registered)
//   level         FIFO occupancy, 0..DEPTH
//   issued_count  events delivered to the monitor, wraps at 2^32
// ---------------------------------------------------------------------------
module rtlola_input_aligner #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4,
  parameter int STAGES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  rtlola_input_aligner_if.slave    prod,
  input  logic signed [63:0]       llc_stage,
  output logic signed [DATA_W-1:0] input_a,
  output logic                     new_input,
  output logic [$clog2(DEPTH):0]   level,
  output logic [31:0]              issued_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic signed [63:0] LAST_STAGE = 64'(STAGES - 1);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]              r_wr_ptr;
  logic [AW:0]              r_rd_ptr;
  logic signed [DATA_W-1:0] r_mem [DEPTH];
  logic signed [DATA_W-1:0] r_input_a;
  logic                     r_new_input;
  logic [31:0]              r_issued_count;
  // Cleared on issue, re-set once the stage leaves the last value: at most
  // one issue per HLC period even if llc_stage stalls at STAGES-1.
  logic                     r_armed;

  logic [AW:0] w_level;
  logic        w_full;
  logic        w_last_stage;
  logic        w_push;
  logic        w_slot;

  assign w_level      = r_wr_ptr - r_rd_ptr;
  assign w_full       = (w_level == (AW + 1)'(DEPTH));
  assign w_last_stage = (llc_stage == LAST_STAGE);
  assign w_push       = en & prod.in_valid & ~w_full;
  // Uses the pre-edge level, so an entry pushed at the issue edge is not
  // eligible until the next slot (no bypass).
  assign w_slot       = en & r_armed & w_last_stage & (w_level != '0);

  assign prod.in_ready = ~w_full;
  assign input_a       = r_input_a;
  assign new_input     = r_new_input;
  assign level         = w_level;
  assign issued_count  = r_issued_count;

  // Storage is not reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= prod.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_input_a      <= '0;
      r_new_input    <= 1'b0;
      r_issued_count <= '0;
      r_armed        <= 1'b1;
    end else begin
      // en=0 makes w_slot low, so the strobe drops to 0 while frozen.
      r_new_input <= w_slot;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_slot) begin
        r_input_a      <= r_mem[r_rd_ptr[AW-1:0]];
        r_rd_ptr       <= r_rd_ptr + 1'b1;
        r_issued_count <= r_issued_count + 32'd1;
      end
      if (en) begin
        if (w_slot) begin
          r_armed <= 1'b0;
        end else if (!w_last_stage) begin
          r_armed <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rtlola_input_aligner.sv
module tb_rtlola_input_aligner;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 4;
  localparam int STAGES = 4;

  // ---------------- clock / reset block ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst;
  logic                     en;
  logic signed [63:0]       llc_stage;
  logic signed [DATA_W-1:0] input_a;
  logic                     new_input;
  logic [$clog2(DEPTH):0]   level;
  logic [31:0]              issued_count;

  rtlola_input_aligner_if #(.DATA_W(DATA_W)) bus ();

  rtlola_input_aligner #(.DATA_W(DATA_W), .DEPTH(DEPTH), .STAGES(STAGES)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .prod         (bus),
    .llc_stage    (llc_stage),
    .input_a      (input_a),
    .new_input    (new_input),
    .level        (level),
    .issued_count (issued_count)
  );

  // ---------------- scoreboard / reference model ----------------
  // Abstract model: a queue of pending events, the last delivered value,
  // a delivery count and a "may issue this HLC period" flag.
  logic [DATA_W-1:0] exp_q[$];
  bit                m_new;
  logic [DATA_W-1:0] m_a;
  logic [31:0]       m_cnt;
  bit                m_armed;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // ---------------- driver task ----------------
  // Applies one cycle of inputs, advances the model by the same rules, and
  // returns #1 after the rising edge so outputs can be sampled.
  task automatic apply(input bit r, input bit e, input bit v,
                       input logic [63:0] d, input longint s);
    bit full;
    bit acc;
    bit slot;
    rst          = r;
    en           = e;
    bus.in_valid = v;
    bus.in_data  = d;
    llc_stage    = s;
    if (!r) begin
      exp_q.delete();
      m_new   = 1'b0;
      m_a     = '0;
      m_cnt   = '0;
      m_armed = 1'b1;
    end else begin
      full  = (exp_q.size() == DEPTH);
      acc   = e && v && !full;
      slot  = e && m_armed && (s == STAGES - 1) && (exp_q.size() != 0);
      m_new = slot;
      if (slot) begin
        m_a = exp_q.pop_front();
        m_cnt++;
      end
      if (acc) exp_q.push_back(d);
      if (e) begin
        if (slot) m_armed = 1'b0;
        else if (s != STAGES - 1) m_armed = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".new_input"}, 64'(new_input), 64'(m_new));
    chk({tag, ".input_a"}, input_a, m_a);
    chk({tag, ".level"}, 64'(level), 64'(exp_q.size()));
    chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'(exp_q.size() != DEPTH));
    chk({tag, ".issued_count"}, 64'(issued_count), 64'(m_cnt));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          r, e, v;
    logic [63:0] d;
    longint      s;
    bit          x_new;
    logic [63:0] x_a;
    int          x_level;
    bit          x_ready;
    int          x_cnt;
  } vec_t;

  function automatic vec_t mk(bit r, bit e, bit v, logic [63:0] d, longint s,
                              bit xn, logic [63:0] xa, int xl, bit xr, int xc);
    vec_t t;
    t.r = r; t.e = e; t.v = v; t.d = d; t.s = s;
    t.x_new = xn; t.x_a = xa; t.x_level = xl; t.x_ready = xr; t.x_cnt = xc;
    return t;
  endfunction

  vec_t tbl[34];

  initial begin
    int issues;
    int phase;
    bit r, e, v;
    longint s;

    rst = 1'b0; en = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; llc_stage = '0;

    // reset, basic single event, then a burst that fills the FIFO
    tbl[0]  = mk(0,0,0, 0,0,  0,0,0,1,0);
    tbl[1]  = mk(1,1,0, 0,0,  0,0,0,1,0);
    tbl[2]  = mk(1,1,1, 7,1,  0,0,1,1,0);
    tbl[3]  = mk(1,1,0, 0,2,  0,0,1,1,0);
    tbl[4]  = mk(1,1,0, 0,3,  1,7,0,1,1);
    tbl[5]  = mk(1,1,0, 0,0,  0,7,0,1,1);
    tbl[6]  = mk(1,1,0, 0,1,  0,7,0,1,1);
    tbl[7]  = mk(1,1,0, 0,2,  0,7,0,1,1);
    tbl[8]  = mk(1,1,0, 0,3,  0,7,0,1,1);
    tbl[9]  = mk(1,1,1, 1,0,  0,7,1,1,1);
    tbl[10] = mk(1,1,1, 2,0,  0,7,2,1,1);
    tbl[11] = mk(1,1,1, 3,0,  0,7,3,1,1);
    tbl[12] = mk(1,1,1, 4,0,  0,7,4,0,1);
    tbl[13] = mk(1,1,1, 5,0,  0,7,4,0,1);
    tbl[14] = mk(1,1,1, 5,1,  0,7,4,0,1);
    tbl[15] = mk(1,1,1, 5,2,  0,7,4,0,1);
    tbl[16] = mk(1,1,1, 5,3,  1,1,3,1,2);
    tbl[17] = mk(1,1,1, 5,0,  0,1,4,0,2);
    tbl[18] = mk(1,1,0, 0,1,  0,1,4,0,2);
    tbl[19] = mk(1,1,0, 0,2,  0,1,4,0,2);
    tbl[20] = mk(1,1,0, 0,3,  1,2,3,1,3);
    tbl[21] = mk(1,1,0, 0,0,  0,2,3,1,3);
    tbl[22] = mk(1,1,0, 0,1,  0,2,3,1,3);
    tbl[23] = mk(1,1,0, 0,2,  0,2,3,1,3);
    tbl[24] = mk(1,1,0, 0,3,  1,3,2,1,4);
    tbl[25] = mk(1,1,0, 0,0,  0,3,2,1,4);
    tbl[26] = mk(1,1,0, 0,1,  0,3,2,1,4);
    tbl[27] = mk(1,1,0, 0,2,  0,3,2,1,4);
    tbl[28] = mk(1,1,0, 0,3,  1,4,1,1,5);
    tbl[29] = mk(1,1,0, 0,0,  0,4,1,1,5);
    tbl[30] = mk(1,1,0, 0,1,  0,4,1,1,5);
    tbl[31] = mk(1,1,0, 0,2,  0,4,1,1,5);
    tbl[32] = mk(1,1,0, 0,3,  1,5,0,1,6);
    tbl[33] = mk(1,1,0, 0,0,  0,5,0,1,6);

    @(posedge clk); #1;
    foreach (tbl[i]) begin
      apply(tbl[i].r, tbl[i].e, tbl[i].v, tbl[i].d, tbl[i].s);
      chk($sformatf("vec%0d.new_input", i), 64'(new_input), 64'(tbl[i].x_new));
      chk($sformatf("vec%0d.input_a", i), input_a, tbl[i].x_a);
      chk($sformatf("vec%0d.level", i), 64'(level), 64'(tbl[i].x_level));
      chk($sformatf("vec%0d.in_ready", i), 64'(bus.in_ready), 64'(tbl[i].x_ready));
      chk($sformatf("vec%0d.issued_count", i), 64'(issued_count), 64'(tbl[i].x_cnt));
    end

    // ---- stalled stage: two queued, stage held at last value ----
    apply(0,1,0,0,0); check_model("stall_rst");
    apply(1,1,1,11,0); check_model("stall_push");
    apply(1,1,1,12,1); check_model("stall_push");
    apply(1,1,0,0,2); check_model("stall_idle");
    issues = 0;
    for (int i = 0; i < 5; i++) begin
      apply(1,1,0,0,3); check_model("stall_hold");
      issues += int'(new_input);
    end
    chk("stall_one_issue", 64'(issues), 64'd1);
    for (int st = 0; st < STAGES; st++) begin
      apply(1,1,0,0,st); check_model("stall_resume");
    end
    chk("stall_second_issue", 64'(new_input), 64'd1);
    chk("stall_second_value", input_a, 64'd12);

    // ---- enable gating ----
    apply(0,1,0,0,0); check_model("gate_rst");
    apply(1,1,1,21,0); check_model("gate_push");
    issues = 0;
    for (int i = 0; i < 8; i++) begin
      apply(1,0,0,0,3); check_model("gate_off");
      issues += int'(new_input);
    end
    chk("gate_no_issue", 64'(issues), 64'd0);
    chk("gate_level", 64'(level), 64'd1);
    apply(1,1,0,0,3); check_model("gate_on");
    chk("gate_issue", 64'(new_input), 64'd1);
    chk("gate_value", input_a, 64'd21);

    // ---- simultaneous push and pop at level 2 ----
    apply(0,1,0,0,0); check_model("pp_rst");
    apply(1,1,1,31,0); check_model("pp_push");
    apply(1,1,1,32,1); check_model("pp_push");
    apply(1,1,0,0,2); check_model("pp_idle");
    chk("pp_level_before", 64'(level), 64'd2);
    apply(1,1,1,33,3); check_model("pp_both");
    chk("pp_level_after", 64'(level), 64'd2);
    chk("pp_first_value", input_a, 64'd31);
    for (int k = 0; k < 2; k++) begin
      for (int st = 0; st < STAGES; st++) begin
        apply(1,1,0,0,st); check_model("pp_drain");
      end
      chk($sformatf("pp_order%0d", k), input_a, 64'(32 + k));
    end

    // ---- reset mid-stream ----
    apply(0,1,0,0,0); check_model("mr_rst");
    apply(1,1,1,9,0); check_model("mr_push");
    apply(1,1,0,0,1); check_model("mr_idle");
    apply(1,1,0,0,2); check_model("mr_idle");
    apply(1,1,0,0,3); check_model("mr_issue");
    apply(1,1,1,41,0); check_model("mr_q");
    apply(1,1,1,42,1); check_model("mr_q");
    apply(1,1,1,43,2); check_model("mr_q");
    chk("mr_level3", 64'(level), 64'd3);
    chk("mr_a9", input_a, 64'd9);
    apply(0,1,0,0,3); check_model("mr_pulse");
    chk("mr_level0", 64'(level), 64'd0);
    chk("mr_a0", input_a, 64'd0);
    chk("mr_cnt0", 64'(issued_count), 64'd0);
    issues = 0;
    for (int i = 0; i < 2 * STAGES; i++) begin
      apply(1,1,0,0,i % STAGES); check_model("mr_after");
      issues += int'(new_input);
    end
    chk("mr_no_issue", 64'(issues), 64'd0);

    // ---- randomized stimulus vs model ----
    phase = 0;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 99) != 0);
      e = ($urandom_range(0, 9) != 0);
      v = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 19))
        0: s = -1;
        1: s = STAGES;
        2: s = 64'h0000_0001_0000_0003;
        3, 4: s = phase;
        default: begin
          phase = (phase + 1) % STAGES;
          s = phase;
        end
      endcase
      apply(r, e, v, {$urandom, $urandom}, s);
      check_model($sformatf("rand%0d", i));
    end

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rtlola_input_aligner.md
# rtlola_input_aligner

Upstream feeder for the generated RTLola monitor (`topEntity`). It accepts input-stream events from a producer over a valid/ready handshake and buffers them in a small FIFO. It presents each event to the monitor's `input_a`/`new_input` pins so that `new_input` is high exactly in the cycle where the monitor's `llc_stage` is 0. This is needed because the LLC runs STAGES× faster than the HLC, and an event presented at any other stage is lost or mis-sampled.

## Interface
Parameters:
- DATA_W, 64, width of event payload and `input_a`
- DEPTH, 4, FIFO entries; power of two, ≥2
- STAGES, 4, LLC stages per HLC cycle; `llc_stage` counts 0..STAGES-1

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  synchronous, active-low reset (asserted when 0)
- en  in  1  global enable, same signal that drives the monitor's `en`
- in_valid  in  1  producer has an event
- in_ready  out  1  aligner can accept; equals !full
- in_data  in  DATA_W  signed event value
- llc_stage  in  64  signed stage index fed back from the monitor
- input_a  out  DATA_W  signed value to monitor, registered
- new_input  out  1  one-cycle event strobe to monitor, registered
- level  out  $clog2(DEPTH)+1  FIFO occupancy
- issued_count  out  32  events delivered to the monitor, wraps at 2^32

## Operation
- Reset, when rst=0 at a rising edge:
  - pointers cleared, `level`=0, `in_ready`=1
  - `input_a`=0, `new_input`=0, `issued_count`=0, `armed`=1
- Push: when en & in_valid & in_ready. `in_data` is written at the tail, tail increments mod DEPTH.
- Slot: `slot = en & armed & (llc_stage == STAGES-1) & (level != 0)`. The comparison is signed 64-bit equality; negative or out-of-range stage values never match.
- Pop/issue on slot:
  - head entry is registered into `input_a`; `new_input`=1 for the next cycle
  - head increments mod DEPTH
  - `issued_count` increments, wrapping from 0xFFFFFFFF to 0
  - `armed` clears
- `armed` re-sets in any cycle where `llc_stage != STAGES-1`. This guarantees at most one issue per HLC period, even if the stage value stalls.
- If `llc_stage == STAGES-1` and `level == 0`, nothing is issued; `new_input`=0 next cycle.
- Otherwise `new_input` returns to 0 the cycle after an issue. `input_a` holds the last issued value indefinitely.
- Simultaneous push and pop: both happen and `level` is unchanged. When full, `in_ready`=0 for that cycle, so no push occurs, even though a pop frees an entry. There is no bypass path.
- Empty-FIFO push at the issue edge: the new entry is not eligible until the next slot.
- en=0 freezes all state: no push, no pop, `armed` unchanged, `new_input` forced to 0 next edge. `in_ready` still reflects !full.

## Timing
- Issue latency: slot detected in cycle t; `new_input`/`input_a` are valid in cycle t+1, coinciding with `llc_stage == 0`.
- Push-to-issue minimum: a push at edge e is eligible at any slot cycle after e. Worst case wait is STAGES cycles plus the queue ahead.
- Throughput: at most 1 event per STAGES cycles. A producer sustaining more fills the FIFO and sees `in_ready`=0.
- Reset mid-operation discards all buffered events. `new_input` is 0 the cycle after reset; the first issue can occur at the first post-reset slot.
- `level` ranges 0..DEPTH; full ⇔ level==DEPTH, empty ⇔ level==0. Pointers carry one extra wrap bit.

## Test plan
- Basic: STAGES=4, stage cycling 0..3. Push 7 at stage 1 → `new_input`=1 with `input_a`=7 in the next stage-0 cycle only; `issued_count`=1; `level` back to 0.
- Burst/full: DEPTH=4; push 1..5 back-to-back with no slots → `in_ready`=0 after 4 accepts, 5 held by the producer. Then run stages → outputs 1,2,3,4,5 on five consecutive stage-0 cycles, each `new_input` pulse one cycle wide.
- Stalled stage: hold `llc_stage`=3 for 5 cycles with 2 events queued → exactly one issue. The second issue happens only after the stage leaves 3 and returns.
- Enable gating: en=0 for 8 cycles with 1 event queued and stage at 3 → no `new_input`, `level`=1. Set en=1 → issue at the next slot.
- Simultaneous push/pop at level 2 → `level` stays 2 and the FIFO order is preserved. At level DEPTH with a slot, `in_ready`=0 and that cycle's push is not accepted.
- Reset mid-stream: 3 events queued, `input_a`=9; pulse rst=0 for 1 cycle → `level`=0, `input_a`=0, `issued_count`=0, and no `new_input` until a new push.
